// File: rtl/registrador_ula.sv
// Datapath executor for the register-control interface: X, Y, Z registers plus a small ALU,
// driven each clock by the per-register command codes from the control decoder.
module registrador_ula #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       Tx,
  input  logic [3:0]       Ty,
  input  logic [3:0]       Tz,
  input  logic [3:0]       Tula,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             zero
);

  localparam logic [3:0] CMD_CLEAR = 4'd0;
  localparam logic [3:0] CMD_LOAD  = 4'd2;
  localparam logic [3:0] CMD_SHFTR = 4'd3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;

  logic [WIDTH:0]   alu_full;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  // Extra MSB of the WIDTH+1 result is the carry on ADD and the borrow on SUB.
  always_comb begin
    alu_full  = '0;
    alu_carry = 1'b0;
    case (Tula)
      OP_ADD: begin
        alu_full  = {1'b0, x} + {1'b0, y};
        alu_carry = alu_full[WIDTH];
      end
      OP_SUB: begin
        alu_full  = {1'b0, x} - {1'b0, y};
        alu_carry = alu_full[WIDTH];
      end
      OP_AND:  alu_full = {1'b0, x & y};
      OP_OR:   alu_full = {1'b0, x | y};
      default: alu_full = {1'b0, x};
    endcase
  end

  assign alu_result = alu_full[WIDTH-1:0];

  function automatic logic [WIDTH-1:0] next_reg(
    input logic [3:0]       cmd,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] src
  );
    case (cmd)
      CMD_CLEAR: next_reg = '0;
      CMD_LOAD:  next_reg = src;
      CMD_SHFTR: next_reg = cur >> 1;
      default:   next_reg = cur;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x     <= '0;
      y     <= '0;
      z     <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      x <= next_reg(Tx, x, data_in);
      y <= next_reg(Ty, y, alu_result);
      z <= next_reg(Tz, z, y);
      if (Ty == CMD_LOAD) begin
        carry <= alu_carry;
        zero  <= (alu_result == '0);
      end else if (Ty == CMD_CLEAR) begin
        carry <= 1'b0;
        zero  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_registrador_ula.sv
// Directed bench for registrador_ula: a reference model pushes expected register/flag
// values into a scoreboard queue on each driven step and they are popped after the edge.
module tb_registrador_ula;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
    logic       c;
    logic       zr;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [3:0] Tx, Ty, Tz, Tula;
  logic [3:0] data_in;
  logic [3:0] x, y, z;
  logic       carry, zero;

  exp_t sb[$];
  logic [3:0] mx, my, mz;
  logic       mc, mzr;
  int passed = 0;
  int total  = 0;

  registrador_ula #(.WIDTH(4)) dut (
    .clock(clock), .reset(reset), .Tx(Tx), .Ty(Ty), .Tz(Tz), .Tula(Tula),
    .data_in(data_in), .x(x), .y(y), .z(z), .carry(carry), .zero(zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ex, ey, ez, input logic ec, ezr);
    chk({tag, ".x"}, {4'd0, x}, {4'd0, ex});
    chk({tag, ".y"}, {4'd0, y}, {4'd0, ey});
    chk({tag, ".z"}, {4'd0, z}, {4'd0, ez});
    chk({tag, ".carry"}, {7'd0, carry}, {7'd0, ec});
    chk({tag, ".zero"}, {7'd0, zero}, {7'd0, ezr});
  endtask

  // Drive one command set, predict with the model, and compare after the edge.
  task automatic step(input logic [3:0] tx, ty, tz, tula, din);
    int   ai, bi, r;
    logic ac;
    exp_t e;
    ai = int'(mx);
    bi = int'(my);
    ac = 1'b0;
    case (tula)
      4'd0: begin r = ai + bi; ac = (r > 15); end
      4'd1: begin r = ai - bi; ac = (ai < bi); end
      4'd2: r = int'(mx & my);
      4'd3: r = int'(mx | my);
      default: r = ai;
    endcase
    r = r & 15;
    Tx = tx; Ty = ty; Tz = tz; Tula = tula; data_in = din;
    if (tz == 4'd0) mz = 4'd0; else if (tz == 4'd2) mz = my; else if (tz == 4'd3) mz = mz >> 1;
    if (ty == 4'd2) begin mc = ac; mzr = (r == 0); end
    else if (ty == 4'd0) begin mc = 1'b0; mzr = 1'b0; end
    if (ty == 4'd0) my = 4'd0; else if (ty == 4'd2) my = r[3:0]; else if (ty == 4'd3) my = my >> 1;
    if (tx == 4'd0) mx = 4'd0; else if (tx == 4'd2) mx = din; else if (tx == 4'd3) mx = mx >> 1;
    e.x = mx; e.y = my; e.z = mz; e.c = mc; e.zr = mzr;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 8'd0, 8'd1);
    end else begin
      e = sb.pop_front();
      chk_all("sb", e.x, e.y, e.z, e.c, e.zr);
    end
  endtask

  initial begin
    reset = 1'b1;
    Tx = 4'd1; Ty = 4'd1; Tz = 4'd1; Tula = 4'd0; data_in = 4'd0;
    mx = 0; my = 0; mz = 0; mc = 0; mzr = 0;
    @(posedge clock);
    #1;
    chk_all("reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // load / move
    step(4'd2, 4'd1, 4'd1, 4'd0, 4'd6);
    step(4'd2, 4'd2, 4'd1, 4'd0, 4'd9);
    chk_all("loadmove", 4'd9, 4'd6, 4'd0, 1'b0, 1'b0);
    // shift and copy
    step(4'd1, 4'd3, 4'd1, 4'd0, 4'd0);
    chk("shift.y", {4'd0, y}, 8'd3);
    step(4'd1, 4'd0, 4'd2, 4'd0, 4'd0);
    chk_all("copy", 4'd9, 4'd0, 4'd3, 1'b0, 1'b0);

    // ADD wrap: 12 + 5
    step(4'd2, 4'd0, 4'd1, 4'd0, 4'd5);
    step(4'd2, 4'd2, 4'd1, 4'd0, 4'd12);
    step(4'd1, 4'd2, 4'd1, 4'd0, 4'd0);
    chk_all("addwrap", 4'd12, 4'd1, 4'd3, 1'b1, 1'b0);
    // SUB to zero: 3 - 3
    step(4'd2, 4'd0, 4'd1, 4'd0, 4'd3);
    step(4'd1, 4'd2, 4'd1, 4'd0, 4'd0);
    step(4'd1, 4'd2, 4'd1, 4'd1, 4'd0);
    chk_all("subzero", 4'd3, 4'd0, 4'd3, 1'b0, 1'b1);
    // SUB borrow: 2 - 5
    step(4'd2, 4'd0, 4'd1, 4'd0, 4'd5);
    step(4'd2, 4'd2, 4'd1, 4'd0, 4'd2);
    step(4'd1, 4'd2, 4'd1, 4'd1, 4'd0);
    chk_all("subborrow", 4'd2, 4'd13, 4'd3, 1'b1, 1'b0);

    // reserved codes hold everything
    for (int i = 0; i < 3; i++) step(4'd7, 4'd7, 4'd7, 4'd9, 4'd15);
    chk_all("reserved", 4'd2, 4'd13, 4'd3, 1'b1, 1'b0);
    step(4'd1, 4'd2, 4'd1, 4'd9, 4'd0);
    chk_all("passx", 4'd2, 4'd2, 4'd3, 1'b0, 1'b0);

    // shifts on X and Z, Y shift alongside Z load, Z clear
    step(4'd3, 4'd3, 4'd2, 4'd0, 4'd0);
    chk_all("shiftcopy", 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
    step(4'd1, 4'd1, 4'd3, 4'd0, 4'd0);
    step(4'd1, 4'd1, 4'd0, 4'd0, 4'd0);

    // simultaneous update with OR, then AND yielding zero
    step(4'd2, 4'd0, 4'd1, 4'd0, 4'd2);
    step(4'd2, 4'd2, 4'd1, 4'd0, 4'd4);
    step(4'd2, 4'd2, 4'd2, 4'd3, 4'd1);
    chk_all("simul", 4'd1, 4'd6, 4'd2, 1'b0, 1'b0);
    step(4'd1, 4'd2, 4'd1, 4'd2, 4'd0);
    chk_all("andzero", 4'd1, 4'd0, 4'd2, 1'b0, 1'b1);

    // build x=5, y=3, z=7 then reset between edges
    step(4'd2, 4'd0, 4'd1, 4'd0, 4'd7);
    step(4'd2, 4'd2, 4'd1, 4'd0, 4'd3);
    step(4'd2, 4'd2, 4'd2, 4'd4, 4'd5);
    chk_all("prereset", 4'd5, 4'd3, 4'd7, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("asyncreset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    mx = 0; my = 0; mz = 0; mc = 0; mzr = 0;
    step(4'd2, 4'd1, 4'd1, 4'd0, 4'd9);
    chk("postreset.x", {4'd0, x}, 8'd9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
